// File: rtl/ls_tile_if.sv
// Bus between the load/store tile, its neighbouring PE and the data memory.
// The slave modport is the tile's view; the master modport is the PE/memory side.
interface ls_tile_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROW_BITS   = 6,
    parameter int unsigned COL_BITS   = 6
);
    logic [ROW_BITS+COL_BITS:0]     ctrl;
    logic                           en;
    logic                           input_ready;
    logic [DATA_WIDTH-1:0]          FromMemoryReg;
    logic [DATA_WIDTH-1:0]          FromPE;
    logic [DATA_WIDTH-1:0]          ToPE;
    logic [DATA_WIDTH-1:0]          ToMemoryReg;
    logic [ROW_BITS+COL_BITS-1:0]   mem_addr;
    logic                           mem_we;
    logic                           output_ready;

    modport slave (
        input  ctrl, en, input_ready, FromMemoryReg, FromPE,
        output ToPE, ToMemoryReg, mem_addr, mem_we, output_ready
    );

    modport master (
        output ctrl, en, input_ready, FromMemoryReg, FromPE,
        input  ToPE, ToMemoryReg, mem_addr, mem_we, output_ready
    );
endinterface

// File: rtl/ls_tile.sv
// West-edge load/store tile: one accepted ctrl word per cycle, 1-cycle registered latency.
// Define LS_FWD_EN to enable store-to-load forwarding from a last-store register.
module ls_tile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROW_BITS   = 6,
    parameter int unsigned COL_BITS   = 6
) (
    input  logic            clk,
    input  logic            reset,
    ls_tile_if.slave        bus
);
    localparam int unsigned AddrBits = ROW_BITS + COL_BITS;

    logic [DATA_WIDTH-1:0] to_pe_q;
    logic [DATA_WIDTH-1:0] to_mem_q;
    logic [AddrBits-1:0]   addr_q;
    logic                  we_q;
    logic                  ready_q;

    logic                  accept;
    logic                  is_store;
    logic [AddrBits-1:0]   op_addr;
    logic [DATA_WIDTH-1:0] load_data;

    assign accept   = bus.en && bus.input_ready;
    assign is_store = bus.ctrl[0];
    assign op_addr  = bus.ctrl[AddrBits:1];

`ifdef LS_FWD_EN
    logic                  fwd_valid_q;
    logic [AddrBits-1:0]   fwd_addr_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    // A load hitting the most recent store must see that data, not the stale memory word.
    always_comb begin
        load_data = bus.FromMemoryReg;
        if (fwd_valid_q && (fwd_addr_q == op_addr)) begin
            load_data = fwd_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else if (accept && is_store) begin
            fwd_valid_q <= 1'b1;
            fwd_addr_q  <= op_addr;
            fwd_data_q  <= bus.FromPE;
        end
    end
`else
    assign load_data = bus.FromMemoryReg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_pe_q  <= '0;
            to_mem_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            if (accept) begin
                addr_q  <= op_addr;
                ready_q <= 1'b1;
                if (is_store) begin
                    to_mem_q <= bus.FromPE;
                    we_q     <= 1'b1;
                end else begin
                    to_pe_q <= load_data;
                end
            end
        end
    end

    assign bus.ToPE         = to_pe_q;
    assign bus.ToMemoryReg  = to_mem_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_we       = we_q;
    assign bus.output_ready = ready_q;
endmodule

// File: tb/tb_ls_tile.sv
// Self-checking bench for ls_tile: directed cases followed by random traffic
// compared against a transaction-level model of the tile.
module tb_ls_tile;
    localparam int unsigned DW = 32;

`ifdef LS_FWD_EN
    localparam bit FwdOn = 1'b1;
`else
    localparam bit FwdOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ls_tile_if #(.DATA_WIDTH(DW), .ROW_BITS(6), .COL_BITS(6)) bus ();

    ls_tile #(.DATA_WIDTH(DW), .ROW_BITS(6), .COL_BITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected architectural outputs plus the last store seen (for forwarding).
    logic [31:0] m_to_pe, m_to_mem;
    logic [11:0] m_addr;
    logic        m_we, m_ready;
    logic        st_valid;
    logic [11:0] st_addr;
    logic [31:0] st_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_to_pe  = '0;
        m_to_mem = '0;
        m_addr   = '0;
        m_we     = 1'b0;
        m_ready  = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ToPE"},         bus.ToPE,                 m_to_pe);
        check({tag, ".ToMemoryReg"},  bus.ToMemoryReg,          m_to_mem);
        check({tag, ".mem_addr"},     {20'd0, bus.mem_addr},    {20'd0, m_addr});
        check({tag, ".mem_we"},       {31'd0, bus.mem_we},      {31'd0, m_we});
        check({tag, ".output_ready"}, {31'd0, bus.output_ready}, {31'd0, m_ready});
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model, compare.
    task automatic cycle(input string tag, input logic e, input logic ir, input logic [12:0] c,
                         input logic [31:0] mem, input logic [31:0] pe);
        bus.en            = e;
        bus.input_ready   = ir;
        bus.ctrl          = c;
        bus.FromMemoryReg = mem;
        bus.FromPE        = pe;
        @(posedge clk);
        m_we    = 1'b0;
        m_ready = 1'b0;
        if (e && ir) begin
            m_addr  = c[12:1];
            m_ready = 1'b1;
            if (c[0]) begin
                m_to_mem = pe;
                m_we     = 1'b1;
                st_valid = 1'b1;
                st_addr  = c[12:1];
                st_data  = pe;
            end else if (FwdOn && st_valid && st_addr == c[12:1]) begin
                m_to_pe = st_data;
            end else begin
                m_to_pe = mem;
            end
        end
        #1;
        check_all(tag);
    endtask

    function automatic logic [12:0] mk(input int row, input int col, input bit op);
        mk = {row[5:0], col[5:0], op};
    endfunction

    initial begin
        // Reset asserted from time zero: outputs clear before any clock edge.
        reset = 1'b1;
        bus.en = 1'b1; bus.input_ready = 1'b1; bus.ctrl = mk(3, 4, 1'b1);
        bus.FromMemoryReg = 32'h1234_5678; bus.FromPE = 32'hCAFE_F00D;
        model_reset();
        #1;
        check_all("reset_async");
        for (int i = 0; i < 3; i++) begin
            bus.ctrl = 13'($urandom);
            bus.en   = 1'($urandom);
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end
        @(negedge clk);
        reset = 1'b0;

        cycle("load",  1'b1, 1'b1, mk(1, 1, 1'b0), 32'd65, 32'd7);
        check("load.addr041", {20'd0, bus.mem_addr}, 32'h041);
        cycle("store", 1'b1, 1'b1, mk(1, 2, 1'b1), 32'd9, 32'd1);
        check("store.addr042", {20'd0, bus.mem_addr}, 32'h042);
        check("store.pe_hold", bus.ToPE, 32'd65);
        cycle("idle",  1'b1, 1'b0, mk(1, 2, 1'b1), 32'd9, 32'd1);

        cycle("gate_ir", 1'b1, 1'b0, mk(7, 7, 1'b1), 32'hAAAA_0000, 32'h5555_1111);
        cycle("gate_en", 1'b0, 1'b1, mk(7, 7, 1'b1), 32'hAAAA_0000, 32'h5555_1111);
        cycle("gate_en_ld", 1'b0, 1'b1, mk(7, 7, 1'b0), 32'hAAAA_0000, 32'h5555_1111);
        cycle("resume", 1'b1, 1'b1, mk(7, 7, 1'b1), 32'hAAAA_0000, 32'h5555_1111);

        cycle("b2b0", 1'b1, 1'b1, mk(1, 1, 1'b0), 32'h0000_0101, 32'h0);
        check("b2b0.addr", {20'd0, bus.mem_addr}, 32'h041);
        cycle("b2b1", 1'b1, 1'b1, mk(1, 2, 1'b1), 32'h0, 32'h0000_0202);
        check("b2b1.addr", {20'd0, bus.mem_addr}, 32'h042);
        cycle("b2b2", 1'b1, 1'b1, mk(2, 3, 1'b0), 32'h0000_0303, 32'h0);
        check("b2b2.addr", {20'd0, bus.mem_addr}, 32'h083);
        cycle("b2b_end", 1'b1, 1'b0, mk(2, 3, 1'b0), 32'h0, 32'h0);

        cycle("fwd_st", 1'b1, 1'b1, mk(5, 5, 1'b1), 32'h0, 32'hDEAD_BEEF);
        cycle("fwd_ld", 1'b1, 1'b1, mk(5, 5, 1'b0), 32'h0, 32'h0);
        check("fwd_ld.direct", bus.ToPE, FwdOn ? 32'hDEAD_BEEF : 32'h0);
        cycle("fwd_miss", 1'b1, 1'b1, mk(5, 6, 1'b0), 32'h0000_0077, 32'h0);

        // Store set up for the next edge, but reset lands first: no strobe may appear.
        bus.en = 1'b1; bus.input_ready = 1'b1; bus.ctrl = mk(9, 9, 1'b1); bus.FromPE = 32'h0BAD_0BAD;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_all("midop_async");
        @(posedge clk);
        #1;
        check_all("midop_edge");
        @(negedge clk);
        reset = 1'b0;
        cycle("post_reset_ld", 1'b1, 1'b1, mk(5, 5, 1'b0), 32'h0000_1111, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic        e, ir;
            logic [12:0] c;
            e  = ($urandom_range(0, 9) != 0);
            ir = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0)
                c = mk($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
            else
                c = 13'($urandom);
            cycle("rand", e, ir, c, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ls_tile.md
Name: ls_tile

Overview:
- Load/store tile at the west edge of the PE array; bridges one PE (FromPE/ToPE) and a 64x64 word data memory (FromMemoryReg/ToMemoryReg).
- Each accepted 13-bit ctrl word is one transfer.
  - Load: memory word to the PE.
  - Store: PE word to memory.
- Drives a registered memory address and write strobe; 1-cycle latency.

Parameters:
- DATA_WIDTH, 32, width of every data path.
- ROW_BITS, 6, row address width (64 rows).
- COL_BITS, 6, column address width (64 columns).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ctrl  in  13  {row[12:7], col[6:1], op[0]}; op 0 = load, 1 = store.
- en  in  1  tile enable; low = frozen.
- input_ready  in  1  ctrl/data valid this cycle.
- FromMemoryReg  in  32  memory read data, valid in the same cycle as the load ctrl.
- FromPE  in  32  store data from the neighbouring PE.
- ToPE  out  32  registered load result to the PE.
- ToMemoryReg  out  32  registered store data to memory.
- mem_addr  out  12  registered {row,col} of the last accepted op.
- mem_we  out  1  one-cycle write strobe, aligned with ToMemoryReg.
- output_ready  out  1  one-cycle pulse: the op accepted on the previous edge is complete.

Behaviour:
- Reset (asynchronous, active-high) clears these outputs to 0:
  - ToPE, ToMemoryReg, mem_addr, mem_we, output_ready.
  - Internal state is cleared as well.
- Reset asserted mid-operation aborts the op; no write strobe is emitted.
- Accept condition: en && input_ready && !reset, sampled at the rising edge.
- On accept, load (ctrl[0]=0):
  - ToPE <= FromMemoryReg.
  - mem_addr <= ctrl[12:1].
  - mem_we <= 0.
  - output_ready <= 1.
  - ToMemoryReg holds its value.
- On accept, store (ctrl[0]=1):
  - ToMemoryReg <= FromPE.
  - mem_addr <= ctrl[12:1].
  - mem_we <= 1.
  - output_ready <= 1.
  - ToPE holds its value.
- Without accept:
  - mem_we <= 0 and output_ready <= 0.
  - ToPE, ToMemoryReg and mem_addr hold.
- en low: tile frozen.
  - Data and address registers hold.
  - Strobes deassert.
  - input_ready is ignored.
- Back-to-back ops are accepted every cycle; no stall and no backpressure.
- Latency is exactly 1 clock from the accepting edge to data/strobe visible.
- Data passes through unmodified: no sign extension, no arithmetic.
- Address is used as given: no wrap or increment; row/col are always in range by width.

Optional Feature:
- Macro LS_FWD_EN enables store-to-load forwarding.
- Defined:
  - The tile keeps a last-store register (valid bit, address, data); reset clears valid.
  - An accepted load whose ctrl[12:1] equals the valid stored address returns the stored data on ToPE instead of FromMemoryReg.
  - The register is updated on every accepted store.
  - A load followed by a store in the next cycle is unaffected.
- Undefined: loads always return FromMemoryReg; no extra state.

Test Plan:
- Reset: assert reset with ctrl/en toggling -> all outputs 0 asynchronously, before any clock edge; outputs stay 0 while reset is held.
- Load: en=1, input_ready=1, ctrl=13'b000001_000001_0, FromMemoryReg=65 -> next edge ToPE=65, mem_addr=12'h041, mem_we=0, output_ready=1 for one cycle.
- Store: ctrl=13'b000001_000010_1, FromPE=1 -> next edge ToMemoryReg=1, mem_addr=12'h042, mem_we=1 for one cycle, ToPE still 65.
- Gating:
  - input_ready=0 or en=0 with store ctrl -> no mem_we, no output_ready, registers unchanged.
  - Re-enable -> normal operation resumes.
- Back-to-back: load(1,1), store(1,2), load(2,3) on consecutive cycles -> three consecutive output_ready pulses; mem_we high only in the second cycle; addresses 041, 042, 083.
- LS_FWD_EN: store FromPE=32'hDEAD_BEEF to (5,5), then load (5,5) with FromMemoryReg=0 -> ToPE=DEADBEEF with the macro defined, 0 without it.
